// File: rtl/operand2_decode_stage_pkg.sv
// operand2_decode_stage_pkg: shift codes, FSM states and operand-2 field positions
package operand2_decode_stage_pkg;
  typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} sh_type_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RS_RD = 2'd1, HOLD = 2'd2} state_e;
  localparam int OP2_IMM8 = 0;
  localparam int OP2_REG = 4;
  localparam int OP2_TYPE = 5;
  localparam int OP2_SHAMT = 7;
  localparam int OP2_ROT = 8;
endpackage

// File: rtl/operand2_decode_stage_if.sv
// operand2_decode_stage_if: valid/ready bus carrying shifter controls
interface operand2_decode_stage_if #(parameter int DATA_W = 32, parameter int SHAMT_W = 8) ();
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] sh_data;
  logic [SHAMT_W-1:0] sh_amt;
  logic [1:0] sh_type;
  logic sh_rrx;
  logic sh_carry_in;
  modport master(output out_valid, sh_data, sh_amt, sh_type, sh_rrx, sh_carry_in, input out_ready);
  modport slave(input out_valid, sh_data, sh_amt, sh_type, sh_rrx, sh_carry_in, output out_ready);
endinterface

// File: rtl/operand2_decode_stage_op2_field_decode.sv
// op2_field_decode: operand-2 field extraction with ARM amount-0 special cases
module op2_field_decode
  import operand2_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHAMT_W = 8
) (
  input  logic              imm,
  input  logic [11:0]       op2,
  input  logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] data,
  output logic [SHAMT_W-1:0] amt,
  output sh_type_e          typ,
  output logic              rrx,
  output logic              reg_shift
);
  logic [4:0] amt5;
  logic zero_amt;
  always_comb begin
    amt5 = op2[OP2_SHAMT +: 5];
    zero_amt = (amt5 == 5'd0);
    reg_shift = ~imm & op2[OP2_REG];
    typ = imm ? SH_ROR : sh_type_e'(op2[OP2_TYPE +: 2]);
    data = imm ? DATA_W'(op2[OP2_IMM8 +: 8]) : rm_data;
    // ROR #0 encodes RRX; LSR/ASR #0 encode a full-width shift
    rrx = ~imm & ~op2[OP2_REG] & zero_amt & (typ == SH_ROR);
    amt = imm ? SHAMT_W'({op2[OP2_ROT +: 4], 1'b0}) :
          reg_shift ? '0 :
          rrx ? SHAMT_W'(1) :
          (zero_amt & ((typ == SH_LSR) | (typ == SH_ASR))) ? SHAMT_W'(DATA_W) :
          SHAMT_W'(amt5);
  end
endmodule

// File: rtl/operand2_decode_stage.sv
// operand2_decode_stage: decodes operand 2 and registers barrel-shifter controls, fetching Rs for register shifts
module operand2_decode_stage
  import operand2_decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHAMT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_op2,
  input  logic              in_imm,
  input  logic [DATA_W-1:0] in_rm_data,
  input  logic              in_carry,
  output logic              rf_re,
  output logic [3:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  operand2_decode_stage_if.master sh
);
  state_e state;
  logic accept;
  logic [DATA_W-1:0] dec_data;
  logic [SHAMT_W-1:0] dec_amt;
  sh_type_e dec_type;
  logic dec_rrx;
  logic dec_reg;
  logic unused_rdata;
  assign unused_rdata = ^rf_rdata[DATA_W-1:SHAMT_W];
  assign in_ready = (state == IDLE) | ((state == HOLD) & sh.out_ready);
  assign accept = in_valid & in_ready & ~flush;
  op2_field_decode #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_dec (
    .imm(in_imm),
    .op2(in_op2),
    .rm_data(in_rm_data),
    .data(dec_data),
    .amt(dec_amt),
    .typ(dec_type),
    .rrx(dec_rrx),
    .reg_shift(dec_reg)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh.out_valid <= 1'b0;
      rf_re <= 1'b0;
      rf_raddr <= '0;
      sh.sh_data <= '0;
      sh.sh_amt <= '0;
      sh.sh_type <= '0;
      sh.sh_rrx <= 1'b0;
      sh.sh_carry_in <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      sh.out_valid <= 1'b0;
      rf_re <= 1'b0;
      rf_raddr <= '0;
    end else if (accept) begin
      state <= dec_reg ? RS_RD : HOLD;
      sh.out_valid <= ~dec_reg;
      rf_re <= dec_reg;
      rf_raddr <= dec_reg ? in_op2[OP2_ROT +: 4] : 4'd0;
      sh.sh_data <= dec_data;
      sh.sh_amt <= dec_amt;
      sh.sh_type <= dec_type;
      sh.sh_rrx <= dec_rrx;
      sh.sh_carry_in <= in_carry;
    end else if (state == RS_RD) begin
      state <= HOLD;
      sh.out_valid <= 1'b1;
      rf_re <= 1'b0;
      rf_raddr <= '0;
      sh.sh_amt <= rf_rdata[SHAMT_W-1:0];
    end else if ((state == HOLD) & sh.out_ready) begin
      state <= IDLE;
      sh.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand2_decode_stage.sv
// tb_operand2_decode_stage: vector table, directed corner sequences and randomized scoreboard run
module tb_operand2_decode_stage;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, in_imm, in_carry, rf_re;
  logic [11:0] in_op2;
  logic [31:0] in_rm_data, rf_rdata;
  logic [3:0] rf_raddr;
  logic [31:0] rf [16];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic imm; logic [11:0] op2; logic [31:0] rm; logic c;
    logic [31:0] data; logic [7:0] amt; logic [1:0] typ; logic rrx;
  } vec_t;
  typedef struct {logic [31:0] data; logic [7:0] amt; logic [1:0] typ; logic rrx; logic c;} exp_t;

  operand2_decode_stage_if #(.DATA_W(32), .SHAMT_W(8)) sh_if ();

  operand2_decode_stage #(.DATA_W(32), .SHAMT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op2(in_op2), .in_imm(in_imm), .in_rm_data(in_rm_data), .in_carry(in_carry),
    .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .sh(sh_if.master)
  );

  always #5 clk = ~clk;
  assign rf_rdata = rf[rf_raddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic imm, input logic [11:0] op2, input logic [31:0] rm, input logic c);
    in_valid = 1'b1; in_imm = imm; in_op2 = op2; in_rm_data = rm; in_carry = c;
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, " out_valid"}, 64'(sh_if.out_valid), 64'd1);
    chk({tag, " sh_data"}, 64'(sh_if.sh_data), 64'(e.data));
    chk({tag, " sh_amt"}, 64'(sh_if.sh_amt), 64'(e.amt));
    chk({tag, " sh_type"}, 64'(sh_if.sh_type), 64'(e.typ));
    chk({tag, " sh_rrx"}, 64'(sh_if.sh_rrx), 64'(e.rrx));
    chk({tag, " sh_carry_in"}, 64'(sh_if.sh_carry_in), 64'(e.c));
  endtask

  // Reference: ARM operand-2 rules in plain arithmetic on the field value
  function automatic exp_t model(input logic imm, input logic [11:0] op2, input logic [31:0] rm, input logic c);
    exp_t e;
    int v, amt5, kind;
    v = int'(op2);
    amt5 = (v / 128) % 32;
    kind = (v / 32) % 4;
    e.c = c;
    e.rrx = 1'b0;
    if (imm) begin
      e.data = 32'(v % 256);
      e.amt = 8'(2 * (v / 256));
      e.typ = 2'd3;
    end else begin
      e.data = rm;
      e.typ = 2'(kind);
      if ((v / 16) % 2 == 1) e.amt = 8'(rf[4'(v / 256)] % 256);
      else if (amt5 == 0 && (kind == 1 || kind == 2)) e.amt = 8'd32;
      else if (amt5 == 0 && kind == 3) begin e.amt = 8'd1; e.rrx = 1'b1; end
      else e.amt = 8'(amt5);
    end
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[9];
    exp_t e, q[$];
    vecs[0] = '{1'b1, 12'h4FF, 32'h12345678, 1'b0, 32'h000000FF, 8'd8, 2'd3, 1'b0};
    vecs[1] = '{1'b0, 12'h020, 32'h80000000, 1'b1, 32'h80000000, 8'd32, 2'd1, 1'b0};
    vecs[2] = '{1'b0, 12'h060, 32'h80000001, 1'b0, 32'h80000001, 8'd1, 2'd3, 1'b1};
    vecs[3] = '{1'b0, 12'h040, 32'hC0000000, 1'b1, 32'hC0000000, 8'd32, 2'd2, 1'b0};
    vecs[4] = '{1'b0, 12'h000, 32'h0000ABCD, 1'b0, 32'h0000ABCD, 8'd0, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 12'hF80, 32'h00000001, 1'b1, 32'h00000001, 8'd31, 2'd0, 1'b0};
    vecs[6] = '{1'b0, 12'h0E6, 32'h00000003, 1'b0, 32'h00000003, 8'd1, 2'd3, 1'b0};
    vecs[7] = '{1'b1, 12'hF01, 32'hFFFFFFFF, 1'b1, 32'h00000001, 8'd30, 2'd3, 1'b0};
    vecs[8] = '{1'b1, 12'h0AB, 32'hFFFFFFFF, 1'b0, 32'h000000AB, 8'd0, 2'd3, 1'b0};
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    rf[3] = 32'h00000120;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = 1'b0; in_op2 = '0; in_rm_data = '0; in_carry = 1'b0;
    sh_if.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset out_valid", 64'(sh_if.out_valid), 0);
    chk("reset rf_re", 64'(rf_re), 0);
    chk("reset rf_raddr", 64'(rf_raddr), 0);
    chk("reset sh_data", 64'(sh_if.sh_data), 0);
    chk("reset sh_amt", 64'(sh_if.sh_amt), 0);
    chk("reset sh_type", 64'(sh_if.sh_type), 0);
    chk("reset sh_rrx", 64'(sh_if.sh_rrx), 0);
    chk("reset sh_carry_in", 64'(sh_if.sh_carry_in), 0);
    chk("reset in_ready", 64'(in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].imm, vecs[i].op2, vecs[i].rm, vecs[i].c);
      sh_if.out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk_out($sformatf("vec%0d", i), '{vecs[i].data, vecs[i].amt, vecs[i].typ, vecs[i].rrx, vecs[i].c});
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 0);
      sh_if.out_ready = 1'b1;
      step();
      chk($sformatf("vec%0d drained", i), 64'(sh_if.out_valid), 0);
    end

    issue(1'b0, 12'h311, 32'hDEADBEEF, 1'b1);
    step();
    in_valid = 1'b0;
    chk("regsh rf_re", 64'(rf_re), 1);
    chk("regsh rf_raddr", 64'(rf_raddr), 3);
    chk("regsh early valid", 64'(sh_if.out_valid), 0);
    chk("regsh in_ready", 64'(in_ready), 0);
    step();
    chk_out("regsh", '{32'hDEADBEEF, 8'h20, 2'd0, 1'b0, 1'b1});
    chk("regsh rf_re off", 64'(rf_re), 0);
    chk("regsh rf_raddr off", 64'(rf_raddr), 0);
    step();
    chk("regsh drained", 64'(sh_if.out_valid), 0);

    e = '{32'hF0F00000, 8'd1, 2'd1, 1'b0, 1'b0};
    issue(1'b0, 12'h0A2, 32'hF0F00000, 1'b0);
    sh_if.out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("stall%0d", i), e);
      chk($sformatf("stall%0d in_ready", i), 64'(in_ready), 0);
      if (i < 2) step();
    end
    sh_if.out_ready = 1'b1;
    issue(1'b1, 12'h4FF, 32'h0, 1'b1);
    #1;
    chk("stall release in_ready", 64'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk_out("stall next", '{32'hFF, 8'd8, 2'd3, 1'b0, 1'b1});
    step();
    chk("stall drained", 64'(sh_if.out_valid), 0);

    issue(1'b0, 12'h311, 32'h11111111, 1'b0);
    step();
    in_valid = 1'b0;
    chk("flush in RS_RD", 64'(rf_re), 1);
    flush = 1'b1;
    sh_if.out_ready = 1'b0;
    step();
    flush = 1'b0;
    chk("flush rf_re", 64'(rf_re), 0);
    chk("flush in_ready", 64'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush quiet%0d", i), 64'(sh_if.out_valid), 0);
      step();
    end
    issue(1'b1, 12'h0AB, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    chk_out("post flush", '{32'hAB, 8'd0, 2'd3, 1'b0, 1'b1});
    sh_if.out_ready = 1'b1;
    step();

    issue(1'b0, 12'h000, 32'h12345678, 1'b1);
    sh_if.out_ready = 1'b0;
    step();
    chk("pre-rst hold", 64'(sh_if.out_valid), 1);
    rst = 1'b1; flush = 1'b1;
    issue(1'b1, 12'h4FF, 32'h0, 1'b1);
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst out_valid", 64'(sh_if.out_valid), 0);
    chk("rst sh_data", 64'(sh_if.sh_data), 0);
    chk("rst sh_amt", 64'(sh_if.sh_amt), 0);
    chk("rst sh_type", 64'(sh_if.sh_type), 0);
    chk("rst sh_carry_in", 64'(sh_if.sh_carry_in), 0);
    chk("rst rf_re", 64'(rf_re), 0);
    chk("rst in_ready", 64'(in_ready), 1);

    sh_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, 12'(i + 1), 32'h0, 1'b0);
      step();
      chk($sformatf("b2b%0d valid", i), 64'(sh_if.out_valid), 1);
      chk($sformatf("b2b%0d data", i), 64'(sh_if.sh_data), 64'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("b2b end", 64'(sh_if.out_valid), 0);

    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    for (int cyc = 0; cyc < 410; cyc++) begin
      step();
      if (cyc < 400) begin
        in_valid = 1'($urandom_range(0, 1));
        issue(1'($urandom_range(0, 1)), 12'($urandom), $urandom, 1'($urandom_range(0, 1)));
        in_valid = 1'($urandom_range(0, 1));
        sh_if.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        sh_if.out_ready = 1'b1;
      end
      #1;
      if (sh_if.out_valid && sh_if.out_ready) begin
        if (q.size() == 0) chk("rnd unexpected output", 1, 0);
        else chk_out("rnd", q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(in_imm, in_op2, in_rm_data, in_carry));
    end
    chk("rnd drain", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
